// File: rtl/toggle_cover_pkg.sv
// toggle_cover_pkg: shared types and constants for the toggle coverage scheduler
package toggle_cover_pkg;
  localparam int COVER_TOTAL = 8744;
  typedef logic [63:0] cover_idx_t;
  typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/toggle_rr_pick.sv
// toggle_rr_pick: combinational round-robin first-one finder starting at ptr
module toggle_rr_pick #(
  parameter int WIDTH = 42,
  localparam int PW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any,
  output logic [PW-1:0]    sel
);
  logic [PW:0] w_j;
  always_comb begin
    any = 1'b0;
    sel = '0;
    w_j = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_j = {1'b0, ptr} + (PW+1)'(i);
      if (w_j >= (PW+1)'(WIDTH)) w_j = w_j - (PW+1)'(WIDTH);
      if (req[w_j[PW-1:0]]) begin
        any = 1'b1;
        sel = w_j[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/toggle_cover_scheduler.sv
// toggle_cover_scheduler: dedups toggle hits and streams first-time cover indices round robin
module toggle_cover_scheduler #(
  parameter int WIDTH       = 42,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = toggle_cover_pkg::COVER_TOTAL
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_index,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       all_covered
);
  import toggle_cover_pkg::*;
  localparam int PW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
    $error("COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_seen, r_pending, w_seen_nxt, w_sel_mask;
  logic [PW-1:0]    r_ptr, w_sel;
  logic             w_any, w_load, w_hs;
  logic [CW-1:0]    w_cnt;
  cover_idx_t       r_index;
  toggle_rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req(r_pending),
    .ptr(r_ptr),
    .any(w_any),
    .sel(w_sel)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = w_load ? OFFER : (out_valid && !out_ready) ? OFFER : IDLE;
  always_comb begin
    out_valid = r_state == OFFER;
    w_hs = out_valid && out_ready;
    w_load = w_any && !clear && (r_state == IDLE || w_hs);
    out_index = r_index;
  end
  always_comb begin
    w_seen_nxt = r_seen | valid;
    w_sel_mask = w_load ? (WIDTH'(1) << w_sel) : '0;
    w_cnt = '0;
    for (int i = 0; i < WIDTH; i++) w_cnt = w_cnt + CW'(w_seen_nxt[i]);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_seen <= '0;
      r_pending <= '0;
      r_ptr <= '0;
      r_index <= '0;
      hit_count <= '0;
      all_covered <= 1'b0;
    end else begin
      if (clear) begin
        r_seen <= '0;
        r_pending <= '0;
        hit_count <= '0;
        all_covered <= 1'b0;
      end else begin
        r_seen <= w_seen_nxt;
        r_pending <= (r_pending & ~w_sel_mask) | (valid & ~r_seen);
        hit_count <= w_cnt;
        all_covered <= &w_seen_nxt;
      end
      if (w_load) begin
        r_index <= cover_idx_t'(COVER_INDEX) + cover_idx_t'(w_sel);
        r_ptr <= (w_sel == PW'(WIDTH - 1)) ? '0 : w_sel + PW'(1);
      end
    end
endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// tb_toggle_cover_scheduler: directed vectors checked against a set-based model and literal expectations
module tb_toggle_cover_scheduler;
  localparam int W = 42;
  localparam int CI = 100;
  logic clock = 1'b0, reset = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [W-1:0] valid = '0;
  logic out_valid, all_covered;
  logic [63:0] out_index;
  logic [5:0] hit_count;
  int vectors = 0, miscompares = 0;
  longint got[$];
  bit m_seen[W], m_pend[W];
  bit m_offer, m_all;
  int m_ptr, m_idx, m_cnt;

  toggle_cover_scheduler #(.WIDTH(W), .COVER_INDEX(CI)) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .hit_count(hit_count), .all_covered(all_covered)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Model: sets of seen/pending points, next report = first pending after the last one reported
  always @(posedge clock or negedge reset) begin
    int sel;
    bit found, load;
    if (!reset) begin
      foreach (m_seen[i]) begin m_seen[i] = 0; m_pend[i] = 0; end
      m_ptr = 0; m_idx = 0; m_offer = 0; m_cnt = 0; m_all = 0;
    end else begin
      found = 0; sel = 0;
      for (int k = 0; k < W; k++)
        if (!found && m_pend[(m_ptr + k) % W]) begin found = 1; sel = (m_ptr + k) % W; end
      load = found && !clear && (!m_offer || out_ready);
      m_offer = load || (m_offer && !out_ready);
      if (load) begin m_idx = CI + sel; m_ptr = (sel + 1) % W; m_pend[sel] = 0; end
      if (clear) begin
        foreach (m_seen[i]) begin m_seen[i] = 0; m_pend[i] = 0; end
        m_cnt = 0; m_all = 0;
      end else begin
        m_cnt = 0;
        for (int b = 0; b < W; b++) begin
          if (valid[b] && !m_seen[b]) begin m_pend[b] = 1; m_seen[b] = 1; end
          m_cnt += int'(m_seen[b]);
        end
        m_all = m_cnt == W;
      end
    end
  end

  always @(posedge clock) begin
    if (reset && out_valid && out_ready) got.push_back(longint'(out_index));
    #1;
    if (reset) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_offer});
      if (m_offer) chk("out_index", out_index, 64'(m_idx));
      chk("hit_count", 64'(hit_count), 64'(m_cnt));
      chk("all_covered", {63'd0, all_covered}, {63'd0, m_all});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic hit(input logic [W-1:0] v);
    valid = v;
    cyc(1);
    valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    got.delete();
  endtask

  initial begin
    cyc(2);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_all_covered", {63'd0, all_covered}, 64'd0);
    chk("rst_out_index", out_index, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    // single hit
    hit(W'(1) << 5);
    cyc(5);
    chk("single_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("single_idx", 64'(got[0]), 64'(CI + 5));
    chk("single_hits", 64'(hit_count), 64'd1);
    // dedup across 10 cycles of the same hit
    clear = 1'b1; cyc(1); clear = 1'b0;
    got.delete();
    valid = W'(1) << 5; cyc(10); valid = '0;
    cyc(5);
    chk("dedup_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("dedup_idx", 64'(got[0]), 64'(CI + 5));
    // burst of every point
    do_reset();
    out_ready = 1'b1;
    hit('1);
    cyc(50);
    chk("burst_count", 64'(got.size()), 64'(W));
    for (int i = 0; i < W && i < got.size(); i++) chk("burst_idx", 64'(got[i]), 64'(CI + i));
    chk("burst_all", {63'd0, all_covered}, 64'd1);
    chk("burst_hits", 64'(hit_count), 64'(W));
    // wrap: report 39 so the search starts at 40, then pend {3,41}
    do_reset();
    hit(W'(1) << 39);
    cyc(5);
    got.delete();
    hit((W'(1) << 3) | (W'(1) << 41));
    cyc(6);
    chk("wrap_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("wrap_first", 64'(got[0]), 64'(CI + 41));
      chk("wrap_second", 64'(got[1]), 64'(CI + 3));
    end
    // backpressure
    do_reset();
    out_ready = 1'b0;
    hit((W'(1) << 2) | (W'(1) << 7));
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_index", out_index, 64'(CI + 2));
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(5);
    chk("bp_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("bp_first", 64'(got[0]), 64'(CI + 2));
      chk("bp_second", 64'(got[1]), 64'(CI + 7));
    end
    // clear while offering
    do_reset();
    out_ready = 1'b0;
    hit((W'(1) << 2) | (W'(1) << 7));
    cyc(2);
    clear = 1'b1; valid = W'(1) << 9;
    cyc(1);
    clear = 1'b0; valid = '0;
    cyc(1);
    chk("clr_hits", 64'(hit_count), 64'd0);
    chk("clr_valid", {63'd0, out_valid}, 64'd1);
    chk("clr_index", out_index, 64'(CI + 2));
    out_ready = 1'b1;
    cyc(5);
    chk("clr_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("clr_idx", 64'(got[0]), 64'(CI + 2));
    got.delete();
    hit(W'(1) << 7);
    cyc(5);
    chk("rehit_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("rehit_idx", 64'(got[0]), 64'(CI + 7));
    // async reset mid-offer
    out_ready = 1'b0;
    hit(W'(1) << 1);
    cyc(3);
    chk("pre_ar_valid", {63'd0, out_valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_hits", 64'(hit_count), 64'd0);
    chk("ar_index", out_index, 64'd0);
    chk("ar_all", {63'd0, all_covered}, 64'd0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
